// File: rtl/lsu_mem_port.sv
// Load/store front end between the execute stage and a word-organised data memory.
// Latency: an aligned access takes 2 cycles from accept to response with a memory that acks one cycle after req; a misaligned access takes 3*beats-1 cycles.
// Backpressure: cpu_ready is low from accept until the response; mem_req is held with stable mem_* until mem_ack or timeout.
//
// Ports: clk/reset (synchronous, active-high); cpu_* is the pipeline request/response side;
//        mem_* is the memory req/ack side. All outputs are registered.
// Optional: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses (error response, no memory beat)
//           instead of splitting them into aligned beats.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  input  logic        cpu_extend,
  output logic        cpu_resp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic        mem_extend,
  output logic [1:0]  mem_width,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] w0_q;
  logic [1:0]  width_q;
  logic        extend_q;
  logic        write_q;
  logic        split_q;
  logic [1:0]  beat_idx;
  logic [1:0]  last_beat;
  logic [31:0] tmo_cnt;

  // Halves need addr[0]=0, words need addr[1:0]=00; bytes are never misaligned.
  logic cpu_mis;
  assign cpu_mis = ((cpu_width == 2'b01) & cpu_addr[0]) | (cpu_width[1] & (|cpu_addr[1:0]));

  logic trap_hit;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = cpu_mis;
`else
  assign trap_hit = 1'b0;
`endif

  // Misaligned load merge: the second word arrives on mem_rdata while the
  // first sits in w0_q; pick 32 bits starting at the original byte offset.
  logic [63:0] pair;
  logic [31:0] lo_word;
  logic [31:0] merged;
  assign pair    = {mem_rdata, w0_q};
  assign lo_word = pair[{addr_q[1:0], 3'b000} +: 32];

  always_comb begin
    merged = lo_word;
    if (width_q == 2'b01)
      merged = {{16{extend_q & lo_word[15]}}, lo_word[15:0]};
  end

  logic tmo_hit;
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cpu_ready      <= 1'b0;
      cpu_resp_valid <= 1'b0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      mem_req        <= 1'b0;
      mem_addr       <= '0;
      mem_write      <= 1'b0;
      mem_wdata      <= '0;
      mem_extend     <= 1'b0;
      mem_width      <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      w0_q           <= '0;
      width_q        <= '0;
      extend_q       <= 1'b0;
      write_q        <= 1'b0;
      split_q        <= 1'b0;
      beat_idx       <= '0;
      last_beat      <= '0;
      tmo_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ready <= 1'b1;
          if (cpu_valid && cpu_ready) begin
            cpu_ready <= 1'b0;
            addr_q    <= cpu_addr;
            wdata_q   <= cpu_wdata;
            width_q   <= cpu_width;
            extend_q  <= cpu_extend;
            write_q   <= cpu_write;
            split_q   <= cpu_mis;
            beat_idx  <= '0;
            tmo_cnt   <= '0;
            if (trap_hit) begin
              state          <= RESP;
              cpu_resp_valid <= 1'b1;
              cpu_err        <= 1'b1;
              cpu_rdata      <= '0;
            end else begin
              if (!cpu_mis) begin
                // Memory handles lane select and extension itself.
                mem_addr   <= cpu_addr;
                mem_width  <= cpu_width;
                mem_extend <= cpu_extend;
                mem_write  <= cpu_write;
                mem_wdata  <= cpu_wdata;
                last_beat  <= 2'd0;
              end else if (!cpu_write) begin
                mem_addr   <= {cpu_addr[31:2], 2'b00};
                mem_width  <= 2'b10;
                mem_extend <= 1'b0;
                mem_write  <= 1'b0;
                mem_wdata  <= '0;
                last_beat  <= 2'd1;
              end else begin
                mem_addr   <= cpu_addr;
                mem_width  <= 2'b00;
                mem_extend <= 1'b0;
                mem_write  <= 1'b1;
                mem_wdata  <= {24'd0, cpu_wdata[7:0]};
                last_beat  <= (cpu_width == 2'b01) ? 2'd1 : 2'd3;
              end
              mem_req <= 1'b1;
              state   <= REQ;
            end
          end
        end

        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            tmo_cnt <= '0;
            if (beat_idx == 2'd0)
              w0_q <= mem_rdata;
            if (beat_idx == last_beat) begin
              state          <= RESP;
              cpu_resp_valid <= 1'b1;
              cpu_err        <= 1'b0;
              cpu_rdata      <= write_q ? 32'd0 : (split_q ? merged : mem_rdata);
            end else begin
              beat_idx <= beat_idx + 2'd1;
              state    <= GAP;
            end
          end else if (tmo_hit) begin
            // Abort: drop any remaining beats; already-acked store bytes stay written.
            mem_req        <= 1'b0;
            state          <= RESP;
            cpu_resp_valid <= 1'b1;
            cpu_err        <= 1'b1;
            cpu_rdata      <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        GAP: begin
          // Only split accesses get here; beat_idx already points at the next beat.
          mem_req <= 1'b1;
          tmo_cnt <= '0;
          state   <= REQ;
          if (!write_q) begin
            mem_addr <= {addr_q[31:2], 2'b00} + 32'd4;
          end else begin
            mem_addr  <= addr_q + {30'd0, beat_idx};
            mem_wdata <= {24'd0, wdata_q[{beat_idx, 3'b000} +: 8]};
          end
        end

        RESP: begin
          cpu_resp_valid <= 1'b0;
          cpu_err        <= 1'b0;
          cpu_rdata      <= '0;
          cpu_ready      <= 1'b1;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: byte-array memory responder with random ack delay,
// plus a byte-level reference model of load/store results and beat plans.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_addr;
  logic        cpu_write;
  logic [31:0] cpu_wdata;
  logic [1:0]  cpu_width;
  logic        cpu_extend;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_extend;
  logic [1:0]  mem_width;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .cpu_write(cpu_write), .cpu_wdata(cpu_wdata), .cpu_width(cpu_width),
    .cpu_extend(cpu_extend), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_extend(mem_extend), .mem_width(mem_width),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents seen by the DUT, and the reference copy.
  logic [7:0] mem_b [0:4095];
  logic [7:0] ref_b [0:4095];

  int          cyc = 0;
  logic        no_ack = 1'b0;
  int          max_delay = 0;
  int          pend = -1;
  logic        served = 1'b0;
  int          req_hi_cnt = 0;
  int          resp_cnt = 0;
  logic [31:0] acc_addr_q[$];
  logic [1:0]  acc_w_q[$];
  logic        acc_ext_q[$];
  int          seen_q[$];
  int          ack_q[$];

  task automatic mem_access();
    logic [11:0] a;
    logic [11:0] wa;
    logic [31:0] v;
    a  = mem_addr[11:0];
    wa = {a[11:2], 2'b00};
    v  = '0;
    acc_addr_q.push_back(mem_addr);
    acc_w_q.push_back(mem_width);
    acc_ext_q.push_back(mem_extend);
    if (mem_write) begin
      case (mem_width)
        2'b00: mem_b[a] = mem_wdata[7:0];
        2'b01: begin mem_b[a] = mem_wdata[7:0]; mem_b[a + 12'd1] = mem_wdata[15:8]; end
        default: for (int i = 0; i < 4; i++) mem_b[wa + 12'(i)] = mem_wdata[8*i +: 8];
      endcase
    end else begin
      case (mem_width)
        2'b00: begin
          v[7:0] = mem_b[a];
          if (mem_extend) v[31:8] = {24{v[7]}};
        end
        2'b01: begin
          v[15:0] = {mem_b[a + 12'd1], mem_b[a]};
          if (mem_extend) v[31:16] = {16{v[15]}};
        end
        default: for (int i = 0; i < 4; i++) v[8*i +: 8] = mem_b[wa + 12'(i)];
      endcase
      mem_rdata = v;
    end
  endtask

  // Memory responder and monitor, acting 1 time unit after each rising edge.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      mem_ack = 1'b0;
      if (mem_req) req_hi_cnt++;
      if (cpu_resp_valid) resp_cnt++;
      if (!mem_req) begin
        pend   = -1;
        served = 1'b0;
      end else if (!served && !no_ack) begin
        if (pend < 0) begin
          pend = $urandom_range(0, max_delay);
          seen_q.push_back(cyc);
        end else if (pend > 0) begin
          pend--;
        end else begin
          mem_access();
          mem_ack = 1'b1;
          served  = 1'b1;
          ack_q.push_back(cyc);
        end
      end
    end
  end

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic ext);
    logic [31:0] v;
    int nb;
    v  = '0;
    nb = nbytes(w);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[12'(a + 32'(i))];
    if (ext && nb == 1) v[31:8] = {24{v[7]}};
    if (ext && nb == 2) v[31:16] = {16{v[15]}};
    return v;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mem_b[12'(a + 32'(i))] = v[8*i +: 8];
      ref_b[12'(a + 32'(i))] = v[8*i +: 8];
    end
  endtask

  // One complete transaction with checks; called at 2 time units after an edge.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [1:0] w, input logic ext, input logic tmo, input string tag);
    int          nb;
    logic        mis;
    logic        trap;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_addr[$];
    logic [1:0]  exp_w;
    logic        exp_ext;
    int          exp_lat;
    int          lat;
    int          n;
    int          r0;
    nb   = nbytes(w);
    mis  = ((w == 2'b01) && addr[0]) || (w[1] && (addr[1:0] != 2'b00));
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = mis;
`endif
    exp_err = trap || tmo;
    exp_rd  = (wr || exp_err) ? 32'd0 : ref_load(addr, w, ext);
    exp_w   = w;
    exp_ext = ext;
    if (!exp_err) begin
      if (!mis) begin
        exp_addr.push_back(addr);
      end else if (!wr) begin
        exp_addr.push_back({addr[31:2], 2'b00});
        exp_addr.push_back({addr[31:2], 2'b00} + 32'd4);
        exp_w = 2'b10; exp_ext = 1'b0;
      end else begin
        for (int i = 0; i < nb; i++) exp_addr.push_back(addr + 32'(i));
        exp_w = 2'b00; exp_ext = 1'b0;
      end
      if (wr) for (int i = 0; i < nb; i++) ref_b[12'(addr + 32'(i))] = wd[8*i +: 8];
    end
    exp_lat = trap ? 0 : tmo ? 8 : 3 * exp_addr.size() - 1;

    acc_addr_q.delete(); acc_w_q.delete(); acc_ext_q.delete();
    seen_q.delete(); ack_q.delete();
    req_hi_cnt = 0;
    r0 = resp_cnt;

    cpu_addr = addr; cpu_write = wr; cpu_wdata = wd; cpu_width = w; cpu_extend = ext;
    cpu_valid = 1'b1;
    n = 0;
    while (!cpu_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (n == 50) begin
      chk({tag, "_accept"}, 32'd0, 32'd1);
      cpu_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    cpu_valid = 1'b0;

    lat = 0;
    while (!cpu_resp_valid && lat < 200) begin @(posedge clk); #2; lat++; end
    if (lat == 200) begin
      chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_rdata"}, cpu_rdata, exp_rd);
    chk({tag, "_err"}, 32'(cpu_err), 32'(exp_err));
    if (max_delay == 0) chk({tag, "_latency"}, lat, exp_lat);
    if (tmo) chk({tag, "_req_hi_cycles"}, req_hi_cnt, 32'd8);
    @(posedge clk); #2;
    chk({tag, "_pulse_len"}, 32'(cpu_resp_valid), 32'd0);
    chk({tag, "_resp_count"}, resp_cnt - r0, 32'd1);
    chk({tag, "_beats"}, acc_addr_q.size(), exp_addr.size());
    for (int i = 0; i < acc_addr_q.size() && i < exp_addr.size(); i++) begin
      chk({tag, "_beat_addr"}, acc_addr_q[i], exp_addr[i]);
      chk({tag, "_beat_width"}, 32'(acc_w_q[i]), 32'(exp_w));
      chk({tag, "_beat_ext"}, 32'(acc_ext_q[i]), 32'(exp_ext));
    end
    for (int i = 0; i + 1 < ack_q.size() && i + 1 < seen_q.size(); i++)
      chk({tag, "_gap"}, seen_q[i + 1] - ack_q[i], 32'd2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int r0;
    int n;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      mem_b[i] = b;
      ref_b[i] = b;
    end
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_write = 1'b0; cpu_wdata = '0;
    cpu_width = '0; cpu_extend = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_width", 32'(mem_width), 32'd0);
    chk("rst_mem_extend", 32'(mem_extend), 32'd0);
    reset = 1'b0;
    @(posedge clk); #2;

    // Directed cases with an immediate-ack memory.
    max_delay = 0;
    put_word(32'h100, 32'h11223344);
    run_txn(32'h100, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0, "ld_word");
    put_word(32'h200, 32'h80000000);
    run_txn(32'h203, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0, "ld_sbyte");
    put_word(32'h100, 32'h44332211);
    put_word(32'h104, 32'h88776655);
    run_txn(32'h101, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0, "ld_mis_word");
    run_txn(32'h102, 1'b1, 32'hAABBCCDD, 2'b10, 1'b0, 1'b0, "st_mis_word");
    run_txn(32'h100, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0, "rb_100");
    run_txn(32'h104, 1'b0, 32'd0, 2'b11, 1'b0, 1'b0, "rb_104");
    run_txn(32'h103, 1'b0, 32'd0, 2'b01, 1'b1, 1'b0, "ld_mis_half");
    run_txn(32'h301, 1'b1, 32'h0000BEEF, 2'b01, 1'b0, 1'b0, "st_mis_half");
    run_txn(32'hFFFFFFFE, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0, "ld_wrap");

    // Randomized traffic with variable ack delay.
    max_delay = 2;
    for (int t = 0; t < 60; t++) begin
      run_txn(32'($urandom_range(0, 4095)), 1'($urandom), $urandom,
              2'($urandom), 1'($urandom), 1'b0, "rand");
    end

    // Memory never acks: timeout aborts with an error.
    max_delay = 0;
    no_ack = 1'b1;
    run_txn(32'h100, 1'b0, 32'd0, 2'b10, 1'b0, 1'b1, "tmo");

    // Reset in the middle of a stalled request.
    cpu_addr = 32'h100; cpu_write = 1'b0; cpu_width = 2'b10; cpu_extend = 1'b0;
    cpu_valid = 1'b1;
    n = 0;
    while (!cpu_ready && n < 50) begin @(posedge clk); #2; n++; end
    @(posedge clk); #2;
    cpu_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    r0 = resp_cnt;
    reset = 1'b1;
    @(posedge clk); #2;
    chk("rstmid_mem_req", 32'(mem_req), 32'd0);
    chk("rstmid_resp_valid", 32'(cpu_resp_valid), 32'd0);
    reset = 1'b0;
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rstmid_ready_after", 32'(cpu_ready), 32'd1);
    repeat (10) @(posedge clk);
    #2;
    chk("rstmid_no_resp", resp_cnt - r0, 32'd0);
    run_txn(32'h104, 1'b0, 32'd0, 2'b10, 1'b0, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Initiator (load/store front end) that sits between the CPU execute stage and the word-organised data memory.
- Accepts one load or store per transaction from the pipeline and drives the memory req/ack handshake.
- Splits misaligned accesses into multiple aligned memory beats, then merges, extends and returns load data.
- Returns a single-cycle completion pulse to the pipeline.

Parameters:
- TIMEOUT_CYCLES, 0, number of cycles req may stay high without ack before the transaction is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cpu_valid  input  1  pipeline request valid
- cpu_ready  output  1  high in IDLE; request accepted on cpu_valid & cpu_ready at posedge
- cpu_addr  input  32  byte address
- cpu_write  input  1  1 = store, 0 = load
- cpu_wdata  input  32  store data, LSB-aligned
- cpu_width  input  2  00 byte, 01 half, 10/11 word
- cpu_extend  input  1  sign-extend byte/half loads
- cpu_resp_valid  output  1  one-cycle completion pulse
- cpu_rdata  output  32  load result, valid with cpu_resp_valid (0 for stores)
- cpu_err  output  1  valid with cpu_resp_valid: timeout or misalign trap
- mem_req  output  1  memory request, registered
- mem_addr  output  32  memory address
- mem_write  output  1  memory write enable
- mem_wdata  output  32  memory write data
- mem_extend  output  1  memory extend control
- mem_width  output  2  memory access width
- mem_ack  input  1  one-cycle acknowledge from memory
- mem_rdata  input  32  memory read data, valid from the ack cycle onward

Behaviour:
- Reset values: cpu_ready=0 during reset, then 1 in IDLE; cpu_resp_valid=0, cpu_err=0, cpu_rdata=0, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_width=0, mem_extend=0.
- All outputs are registered.
- States: IDLE, REQ, GAP, RESP.
- IDLE: on accept, latch the request, compute the beat plan, set mem_* for beat 0, mem_req<=1, go to REQ.
- REQ: hold mem_* stable until mem_ack is sampled high.
  - On that edge: mem_req<=0 and capture mem_rdata for loads.
  - If beats remain, go to GAP; otherwise go to RESP.
- GAP: exactly one cycle with mem_req low. Load the next beat's mem_*, mem_req<=1, go to REQ.
- RESP: cpu_resp_valid=1 for exactly one cycle with cpu_rdata/cpu_err, then go to IDLE.
- Aligned-access latency: accept at edge E0, ack visible after E1, cpu_resp_valid high after E2.
- Beat plan:
  - Aligned access (byte; half with addr[0]=0; word with addr[1:0]=00): 1 beat, passing cpu width/extend/addr through. Memory performs lane select and extension.
  - Misaligned load: 2 word beats at A0=addr&~3 and A1=A0+4 (mod 2^32), mem_extend=0. Result = low bits of ({W1,W0} >> 8*addr[1:0]). For half, take 16 bits and sign/zero-extend per cpu_extend. For word, take 32 bits.
  - Misaligned store: N byte beats (N=2 half, 4 word) at addr+i (mod 2^32), data byte i of cpu_wdata, width 00.
- mem_ack sampled while not in REQ is ignored.
- mem_ack is never expected in the same cycle mem_req rises.
- Timeout: if TIMEOUT_CYCLES>0 and REQ lasts TIMEOUT_CYCLES cycles without ack:
  - mem_req<=0, remaining beats dropped;
  - go to RESP with cpu_err=1, cpu_rdata=0.
  - Store beats already acked stay committed.
- Reset mid-transaction: next edge forces IDLE and the reset values. A late ack is ignored; no response is emitted.
- cpu_valid while not cpu_ready is ignored. The pipeline holds the request until accepted.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses issue no memory beat. Next cycle after accept: RESP with cpu_err=1, cpu_rdata=0, and mem_req never rises.
- Undefined: misaligned accesses are split as above and cpu_err is set only by timeout.

Test Plan:
- Word at 0x100 = 0x11223344; load word from 0x100 -> one beat, mem_addr=0x100, width=10; cpu_resp_valid 2 cycles after accept; rdata=0x11223344, err=0.
- Word 0x80000000 at 0x200; signed byte load from 0x203 -> one beat, width=00, extend=1; rdata=0xFFFFFF80.
- Words 0x44332211 at 0x100 and 0x88776655 at 0x104; load word from 0x101 -> two word beats 0x100 then 0x104, one idle cycle between; rdata=0x55443322.
- Store word 0xAABBCCDD to 0x102 -> four byte writes: 0x102=DD, 0x103=CC, 0x104=BB, 0x105=AA; readback at 0x100/0x104 confirms; single resp pulse.
- TIMEOUT_CYCLES=8 with memory never acking -> mem_req falls after 8 cycles, resp_valid with err=1. Reset asserted mid-REQ -> mem_req=0 next edge, no resp pulse, cpu_ready=1 after reset releases.
- LSU_MISALIGN_TRAP_EN defined; half load from 0x103 -> no mem_req, resp_valid with err=1, rdata=0.
